// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA decrypt block: controller state
// encoding, message-length default, address/data widths and the bounds used
// by the optional plaintext ASCII check.
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    // Working S-box is 256 bytes; the message ROM/RAM hold up to 32 bytes.
    localparam int S_AW   = 8;
    localparam int ROM_AW = 5;
    localparam int DW     = 8;

    // Accepted plaintext: lowercase letters and space.
    localparam logic [DW-1:0] ASCII_LO    = 8'h61;
    localparam logic [DW-1:0] ASCII_HI    = 8'h7A;
    localparam logic [DW-1:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        RD_J,
        WR_I,
        WR_J,
        RD_F,
        WR_OUT,
        DONE
    } prga_state_e;

endpackage

// File: rtl/prga_ascii_check.sv
// Combinational plaintext test: a decrypted byte is acceptable when it is a
// lowercase letter or a space. Used only when PRGA_ASCII_CHECK_EN is defined.
module prga_ascii_check
    import rc4_pkg::*;
(
    input  logic [DW-1:0] data_i,
    output logic          ok_o
);

    assign ok_o = ((data_i >= ASCII_LO) && (data_i <= ASCII_HI)) ||
                  (data_i == ASCII_SPACE);

endmodule

// File: rtl/prga_decrypt.sv
// RC4 PRGA decryptor. Walks the keystream one byte at a time over an external
// synchronous S-memory (1-cycle read latency), XORs it with the encrypted
// message ROM and writes the plaintext to an output RAM. Six cycles per byte:
// RD_I, RD_J, WR_I, WR_J, RD_F, WR_OUT, then a single DONE cycle.
//
// Build option: define PRGA_ASCII_CHECK_EN to stop on the first decrypted byte
// that is not a lowercase letter or space; that byte is not written, key_bad
// is raised and the run finishes early. Without it key_bad is constant 0.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              In_Start,
    output logic              Decrypt_Finish,
    output logic              key_bad,
    output logic [S_AW-1:0]   s_address,
    output logic [DW-1:0]     s_data,
    output logic              s_wren,
    input  logic [DW-1:0]     s_q,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [DW-1:0]     rom_q,
    output logic [ROM_AW-1:0] out_address,
    output logic [DW-1:0]     out_data,
    output logic              out_wren
);

    localparam logic [ROM_AW-1:0] K_LAST = ROM_AW'(MSG_LEN - 1);

    prga_state_e       state_q, state_d;
    logic [S_AW-1:0]   i_q, i_d;
    logic [S_AW-1:0]   j_q, j_d;
    logic [DW-1:0]     si_q, si_d;
    logic [DW-1:0]     sj_q, sj_d;
    logic [ROM_AW-1:0] k_q, k_d;
    logic              done_q, done_d;

    // Plaintext candidate: keystream byte (S read) XOR ciphertext (ROM read),
    // both valid in WR_OUT because their addresses were presented in RD_F.
    logic [DW-1:0] plain_byte;
    logic          byte_ok;

    assign plain_byte = s_q ^ rom_q;

`ifdef PRGA_ASCII_CHECK_EN
    logic key_bad_q, key_bad_d;

    prga_ascii_check u_ascii_check (
        .data_i (plain_byte),
        .ok_o   (byte_ok)
    );

    // key_bad clears on an accepted start and sets on a rejected byte.
    always_comb begin
        key_bad_d = key_bad_q;
        if ((state_q == IDLE) && In_Start) begin
            key_bad_d = 1'b0;
        end else if ((state_q == WR_OUT) && !byte_ok) begin
            key_bad_d = 1'b1;
        end
    end

    // key_bad register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_bad_q <= 1'b0;
        end else begin
            key_bad_q <= key_bad_d;
        end
    end

    assign key_bad = key_bad_q;
`else
    assign byte_ok = 1'b1;
    assign key_bad = 1'b0;
`endif

    // Controller next-state and datapath register updates.
    always_comb begin
        // NOTE: every variable gets a default up front so no path can leave
        // it unassigned; an unassigned path in always_comb infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (In_Start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                state_d = RD_J;
            end
            RD_J: begin
                // s_q now holds S[i].
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = WR_I;
            end
            WR_I: begin
                // s_q now holds S[j] for the updated j.
                sj_d    = s_q;
                state_d = WR_J;
            end
            WR_J: begin
                state_d = RD_F;
            end
            RD_F: begin
                state_d = WR_OUT;
            end
            WR_OUT: begin
                if (!byte_ok || (k_q == K_LAST)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = k_q + 1'b1;
                    state_d = RD_I;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers; reset returns to IDLE mid-run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    assign Decrypt_Finish = done_q;

    // Memory port decode. Addresses are combinational from state because the
    // RD_J address depends on the S[i] value arriving on s_q that same cycle.
    // Everything idles at 0, so reset also forces addresses and data to 0.
    always_comb begin
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        out_address = '0;
        out_data    = '0;
        out_wren    = 1'b0;

        case (state_q)
            RD_I: begin
                s_address = i_q;
            end
            RD_J: begin
                s_address = j_q + s_q;
            end
            WR_I: begin
                // S[i] <= S[j]; when i == j this rewrites the same value.
                s_address = i_q;
                s_data    = s_q;
                s_wren    = 1'b1;
            end
            WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            RD_F: begin
                s_address   = si_q + sj_q;
                rom_address = k_q;
            end
            WR_OUT: begin
                out_address = k_q;
                out_data    = plain_byte;
                out_wren    = byte_ok;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed bench for prga_decrypt with behavioural S-memory, message ROM and
// output RAM, all synchronous with one cycle of read latency.
module tb_prga_decrypt;

    localparam int MSG_LEN = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       In_Start;
    logic       Decrypt_Finish;
    logic       key_bad;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [4:0] out_address;
    logic [7:0] out_data;
    logic       out_wren;

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .In_Start       (In_Start),
        .Decrypt_Finish (Decrypt_Finish),
        .key_bad        (key_bad),
        .s_address      (s_address),
        .s_data         (s_data),
        .s_wren         (s_wren),
        .s_q            (s_q),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .out_address    (out_address),
        .out_data       (out_data),
        .out_wren       (out_wren)
    );

    // Behavioural memories.
    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [32];
    logic [7:0] out_mem [32];
    logic       out_wr  [32];
    logic       s_init;
    logic       out_clr;

    always @(posedge clk) begin
        if (s_init) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
        end else if (s_wren) begin
            s_mem[s_address] <= s_data;
        end
        s_q   <= s_mem[s_address];
        rom_q <= rom_mem[rom_address];
        if (out_clr) begin
            for (int x = 0; x < 32; x++) begin
                out_mem[x] <= 8'h00;
                out_wr[x]  <= 1'b0;
            end
        end else if (out_wren) begin
            out_mem[out_address] <= out_data;
            out_wr[out_address]  <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference RC4 PRGA over an array copy of S.
    logic [7:0] ref_s   [256];
    logic [7:0] ref_out [32];

    task automatic ref_reset();
        for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    endtask

    task automatic ref_run();
        logic [7:0] ri, rj, t, idx;
        ri = 8'd1;
        rj = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            rj        = rj + ref_s[ri];
            t         = ref_s[ri];
            ref_s[ri] = ref_s[rj];
            ref_s[rj] = t;
            idx       = ref_s[ri] + ref_s[rj];
            ref_out[k] = ref_s[idx] ^ rom_mem[k];
            ri        = ri + 8'd1;
        end
    endtask

    task automatic init_mem();
        @(negedge clk);
        s_init  = 1'b1;
        out_clr = 1'b1;
        @(negedge clk);
        s_init  = 1'b0;
        out_clr = 1'b0;
    endtask

    task automatic set_rom(input logic [7:0] b0, input logic [7:0] b1);
        for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
        rom_mem[0] = b0;
        rom_mem[1] = b1;
    endtask

    // Snapshots of S taken during a run.
    logic [7:0] snap_s1, snap_s2, snap_s3;

    // Start a run (In_Start high in cycle 0) and observe up to max_cyc cycles.
    // Finish cycles are -1 when never seen. abort_at > 0 pulls reset low in
    // that cycle and checks that all outputs drop to 0 immediately.
    task automatic do_run(input int pulse2, input bit hold, input int abort_at,
                          input int max_cyc, output int fin1, output int fin2,
                          output int nfin);
        int cyc;
        bit stop;
        fin1 = -1;
        fin2 = -1;
        nfin = 0;
        cyc  = 0;
        stop = 1'b0;
        @(negedge clk);
        In_Start = 1'b1;
        while (!stop && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            In_Start = hold || (cyc == pulse2);
            if (cyc == 6)  snap_s1 = s_mem[1];
            if (cyc == 12) begin
                snap_s2 = s_mem[2];
                snap_s3 = s_mem[3];
            end
            if (Decrypt_Finish) begin
                nfin++;
                if (fin1 < 0) fin1 = cyc;
                else if (fin2 < 0) fin2 = cyc;
            end
            if (cyc == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_s_port", {8'h0, s_address, s_data, 7'h0, s_wren}, 32'h0);
                check("abort_out_port",
                      {5'h0, rom_address, out_address, out_data, 5'h0,
                       out_wren, Decrypt_Finish, key_bad}, 32'h0);
                stop = 1'b1;
            end
        end
        In_Start = 1'b0;
    endtask

    int f1, f2, nf;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        In_Start = 1'b0;
        s_init   = 1'b0;
        out_clr  = 1'b0;
        set_rom(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_s_port", {8'h0, s_address, s_data, 7'h0, s_wren}, 32'h0);
        check("reset_out_port",
              {5'h0, rom_address, out_address, out_data, 5'h0,
               out_wren, Decrypt_Finish, key_bad}, 32'h0);
        reset_n = 1'b1;

        // Plaintext 0x61 then 0x00.
        set_rom(8'h63, 8'h05);
        init_mem();
        do_run(-1, 1'b0, 0, 200, f1, f2, nf);
        check("ascii_out0", {24'h0, out_mem[0]}, 32'h61);
        check("ascii_out0_wr", {31'h0, out_wr[0]}, 32'h1);
        check("ascii_nfin", nf, 32'd1);
`ifdef PRGA_ASCII_CHECK_EN
        check("ascii_fin_cycle", f1, 32'd13);
        check("ascii_key_bad", {31'h0, key_bad}, 32'h1);
        check("ascii_out1_wr", {31'h0, out_wr[1]}, 32'h0);
`else
        check("ascii_fin_cycle", f1, 32'd193);
        check("ascii_key_bad", {31'h0, key_bad}, 32'h0);
        check("ascii_out1", {23'h0, out_wr[1], out_mem[1]}, 32'h100);

        // Identity S, zero ciphertext: raw keystream.
        set_rom(8'h00, 8'h00);
        init_mem();
        ref_reset();
        ref_run();
        do_run(-1, 1'b0, 0, 200, f1, f2, nf);
        check("id_fin_cycle", f1, 32'd193);
        check("id_nfin", nf, 32'd1);
        check("id_s1_after_byte0", {24'h0, snap_s1}, 32'h01);
        check("id_s2_after_byte1", {24'h0, snap_s2}, 32'h03);
        check("id_s3_after_byte1", {24'h0, snap_s3}, 32'h02);
        check("id_out0", {24'h0, out_mem[0]}, 32'h02);
        check("id_out1", {24'h0, out_mem[1]}, 32'h05);
        check("id_out2", {24'h0, out_mem[2]}, 32'h07);
        check("id_out3", {24'h0, out_mem[3]}, 32'h0d);
        for (int k = 0; k < MSG_LEN; k++) begin
            check($sformatf("id_model_out%0d", k), {23'h0, out_wr[k], out_mem[k]},
                  {23'h0, 1'b1, ref_out[k]});
        end

        // Reset mid-run, then a clean restart.
        init_mem();
        do_run(-1, 1'b0, 50, 60, f1, f2, nf);
        check("abort_no_finish", nf, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        init_mem();
        do_run(-1, 1'b0, 0, 200, f1, f2, nf);
        check("restart_fin_cycle", f1, 32'd193);
        check("restart_out0", {24'h0, out_mem[0]}, 32'h02);
        check("restart_out1", {24'h0, out_mem[1]}, 32'h05);
        check("restart_s2", {24'h0, snap_s2}, 32'h03);

        // Second start pulse mid-run is ignored.
        init_mem();
        do_run(20, 1'b0, 0, 240, f1, f2, nf);
        check("pulse_fin_cycle", f1, 32'd193);
        check("pulse_nfin", nf, 32'd1);

        // Start held high: back-to-back runs, second over the permuted S.
        init_mem();
        ref_reset();
        ref_run();
        ref_run();
        do_run(-1, 1'b1, 0, 390, f1, f2, nf);
        check("hold_fin1", f1, 32'd193);
        check("hold_fin2", f2, 32'd387);
        check("hold_nfin", nf, 32'd2);
        for (int k = 0; k < MSG_LEN; k++) begin
            check($sformatf("hold_run2_out%0d", k), {24'h0, out_mem[k]},
                  {24'h0, ref_out[k]});
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif

`ifdef PRGA_ASCII_CHECK_EN
        // key_bad holds while idle, clears on the next accepted start.
        repeat (20) @(negedge clk);
        check("key_bad_hold", {31'h0, key_bad}, 32'h1);
        set_rom(8'h61, 8'h00);
        init_mem();
        do_run(-1, 1'b0, 0, 10, f1, f2, nf);
        check("key_bad_cleared", {31'h0, key_bad}, 32'h0);
        check("cleared_out0", {24'h0, out_mem[0]}, 32'h63);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
